systolic_mac_pe: RTL and testbench

- Parametrised processing element for the output-stationary systolic matrix-multiply array; next generation of the 4-bit unsigned MAC cell.
- Each PE does the following:
  - Multiplies the operand arriving from the west by the operand arriving from the north.
  - Accumulates the product locally.
  - Forwards both operands, with valid/first tags, east and south after one register stage.
- Adds signed/unsigned mode, saturation with a sticky overflow flag, in-band accumulator restart and a result drain shift chain, so a row of PEs can unload results without stalling the array.

---
 rtl/systolic_mac_pe_if.sv | 43 ++++
 rtl/systolic_mac_pe.sv | 166 ++++++++++++++++
 tb/tb_systolic_mac_pe.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_mac_pe_if.sv
// Port bundle of one systolic MAC processing element: operand inputs from
// west/north, forwarded operands east/south, accumulator status and the
// result drain chain.
//   master : drives operands, drain controls and drain_in (upstream side)
//   slave  : the PE itself; drives east/south, result, ovf, err, drain_out
interface systolic_mac_pe_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32
);
  logic [DATA_W-1:0] west_data;
  logic              west_valid;
  logic              west_first;
  logic [DATA_W-1:0] north_data;
  logic              north_valid;
  logic [DATA_W-1:0] east_data;
  logic              east_valid;
  logic              east_first;
  logic [DATA_W-1:0] south_data;
  logic              south_valid;
  logic [ACC_W-1:0]  result;
  logic              ovf;
  logic              err;
  logic              drain_load;
  logic              drain_shift;
  logic [ACC_W-1:0]  drain_in;
  logic              drain_in_valid;
  logic [ACC_W-1:0]  drain_out;
  logic              drain_out_valid;

  modport master (
    output west_data, west_valid, west_first, north_data, north_valid,
    output drain_load, drain_shift, drain_in, drain_in_valid,
    input  east_data, east_valid, east_first, south_data, south_valid,
    input  result, ovf, err, drain_out, drain_out_valid
  );

  modport slave (
    input  west_data, west_valid, west_first, north_data, north_valid,
    input  drain_load, drain_shift, drain_in, drain_in_valid,
    output east_data, east_valid, east_first, south_data, south_valid,
    output result, ovf, err, drain_out, drain_out_valid
  );
endinterface

// File: rtl/systolic_mac_pe.sv
// Output-stationary systolic MAC processing element.
// Multiplies west x north operands, accumulates locally (signed/unsigned,
// saturating or wrapping), forwards operands east/south after one register
// stage, and exposes the accumulator through a shift-out drain chain.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, clears every register
//   pe   - systolic_mac_pe_if.slave bundle (operands, forwards, result,
//          sticky ovf/err flags, drain chain)
// Parameters: DATA_W >= 2, ACC_W >= 2*DATA_W, SIGNED, SAT.
module systolic_mac_pe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter bit          SIGNED = 1'b1,
  parameter bit          SAT    = 1'b1
) (
  input logic             clk,
  input logic             rst,
  systolic_mac_pe_if.slave pe
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ACC_W + 1;

  logic              fire;
  logic              misalign;
  logic [PROD_W-1:0] west_ext;
  logic [PROD_W-1:0] north_ext;
  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  prod_ext;
  logic [SUM_W-1:0]  acc_ext;
  logic [SUM_W-1:0]  sum;
  logic              sum_ovf;
  logic [ACC_W-1:0]  sat_val;

  logic [ACC_W-1:0]  acc_q, acc_nxt;
  logic              ovf_q, ovf_nxt;
  logic              err_q;
  logic [ACC_W-1:0]  drain_q, drain_nxt;
  logic              drain_vld_q, drain_vld_nxt;

  logic [DATA_W-1:0] east_data_q, south_data_q;
  logic              east_valid_q, east_first_q, south_valid_q;

  assign fire     = pe.west_valid & pe.north_valid;
  assign misalign = pe.west_valid ^ pe.north_valid;

  // Operands extended to full product width; the low PROD_W bits of the
  // extended multiply are the exact signed or unsigned product.
  always_comb begin
    west_ext  = {{DATA_W{1'b0}}, pe.west_data};
    north_ext = {{DATA_W{1'b0}}, pe.north_data};
    if (SIGNED) begin
      west_ext  = {{DATA_W{pe.west_data[DATA_W-1]}}, pe.west_data};
      north_ext = {{DATA_W{pe.north_data[DATA_W-1]}}, pe.north_data};
    end
  end

  assign prod = PROD_W'(west_ext * north_ext);

  // One extra bit on the add so overflow is visible in the sum itself.
  always_comb begin
    prod_ext = {{(SUM_W-PROD_W){1'b0}}, prod};
    acc_ext  = {1'b0, acc_q};
    if (SIGNED) begin
      prod_ext = {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod};
      acc_ext  = {acc_q[ACC_W-1], acc_q};
    end
  end

  assign sum = acc_ext + prod_ext;

  // Signed: top two bits disagree. Unsigned: carry out (product is never
  // negative, so only the upper bound can be crossed).
  always_comb begin
    sum_ovf = sum[SUM_W-1];
    sat_val = '1;
    if (SIGNED) begin
      sum_ovf = sum[SUM_W-1] ^ sum[SUM_W-2];
      sat_val = sum[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                             : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Accumulator and overflow next state; a first beat restarts both.
  always_comb begin
    acc_nxt = acc_q;
    ovf_nxt = ovf_q;
    if (fire) begin
      if (pe.west_first) begin
        acc_nxt = prod_ext[ACC_W-1:0];
        ovf_nxt = 1'b0;
      end else begin
        acc_nxt = (SAT && sum_ovf) ? sat_val : sum[ACC_W-1:0];
        if (sum_ovf) begin
          ovf_nxt = 1'b1;
        end
      end
    end
  end

  // Drain register: load takes the post-update accumulator and wins over shift.
  always_comb begin
    drain_nxt     = drain_q;
    drain_vld_nxt = drain_vld_q;
    if (pe.drain_load) begin
      drain_nxt     = acc_nxt;
      drain_vld_nxt = 1'b1;
    end else if (pe.drain_shift) begin
      drain_nxt     = pe.drain_in;
      drain_vld_nxt = pe.drain_in_valid;
    end
  end

  // Accumulator, flags and drain state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      drain_q     <= '0;
      drain_vld_q <= 1'b0;
    end else begin
      acc_q       <= acc_nxt;
      ovf_q       <= ovf_nxt;
      drain_q     <= drain_nxt;
      drain_vld_q <= drain_vld_nxt;
      if (misalign) begin
        err_q <= 1'b1;
      end
    end
  end

  // Operand forwarding; data holds when its valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      east_data_q   <= '0;
      east_valid_q  <= 1'b0;
      east_first_q  <= 1'b0;
      south_data_q  <= '0;
      south_valid_q <= 1'b0;
    end else begin
      east_valid_q  <= pe.west_valid;
      east_first_q  <= pe.west_first & pe.west_valid;
      south_valid_q <= pe.north_valid;
      if (pe.west_valid) begin
        east_data_q <= pe.west_data;
      end
      if (pe.north_valid) begin
        south_data_q <= pe.north_data;
      end
    end
  end

  assign pe.east_data       = east_data_q;
  assign pe.east_valid      = east_valid_q;
  assign pe.east_first      = east_first_q;
  assign pe.south_data      = south_data_q;
  assign pe.south_valid     = south_valid_q;
  assign pe.result          = acc_q;
  assign pe.ovf             = ovf_q;
  assign pe.err             = err_q;
  assign pe.drain_out       = drain_q;
  assign pe.drain_out_valid = drain_vld_q;

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Testbench for systolic_mac_pe: a 3-PE drain chain (8/32, signed, saturating)
// plus a 16-bit signed saturating PE and a 16-bit unsigned wrapping PE.
module tb_systolic_mac_pe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  wd [5];
  logic [7:0]  nd [5];
  logic        wv [5];
  logic        nv [5];
  logic        wf [5];
  logic        dl [5];
  logic        ds [5];

  logic [7:0]  ed [5];
  logic [7:0]  sd [5];
  logic        ev [5];
  logic        sv [5];
  logic        ef [5];
  logic        ovf_o [5];
  logic        err_o [5];
  logic [31:0] res32 [3];
  logic [31:0] dout [3];
  logic        dov [3];
  logic [15:0] res16 [2];

  int checks   = 0;
  int failures = 0;

  for (genvar i = 0; i < 3; i++) begin : g_chain
    systolic_mac_pe_if #(.DATA_W(8), .ACC_W(32)) ifc ();
    assign ifc.west_data   = wd[i];
    assign ifc.west_valid  = wv[i];
    assign ifc.west_first  = wf[i];
    assign ifc.north_data  = nd[i];
    assign ifc.north_valid = nv[i];
    assign ifc.drain_load  = dl[i];
    assign ifc.drain_shift = ds[i];
    if (i == 0) begin : g_head
      assign ifc.drain_in       = '0;
      assign ifc.drain_in_valid = 1'b0;
    end else begin : g_link
      assign ifc.drain_in       = dout[i-1];
      assign ifc.drain_in_valid = dov[i-1];
    end
    assign ed[i]    = ifc.east_data;
    assign sd[i]    = ifc.south_data;
    assign ev[i]    = ifc.east_valid;
    assign sv[i]    = ifc.south_valid;
    assign ef[i]    = ifc.east_first;
    assign ovf_o[i] = ifc.ovf;
    assign err_o[i] = ifc.err;
    assign res32[i] = ifc.result;
    assign dout[i]  = ifc.drain_out;
    assign dov[i]   = ifc.drain_out_valid;
    systolic_mac_pe #(.DATA_W(8), .ACC_W(32), .SIGNED(1'b1), .SAT(1'b1)) u_pe (
      .clk (clk),
      .rst (rst),
      .pe  (ifc)
    );
  end

  // j=0: signed saturating, j=1: unsigned wrapping; both ACC_W=16.
  for (genvar j = 0; j < 2; j++) begin : g_acc16
    systolic_mac_pe_if #(.DATA_W(8), .ACC_W(16)) ifc ();
    assign ifc.west_data      = wd[j+3];
    assign ifc.west_valid     = wv[j+3];
    assign ifc.west_first     = wf[j+3];
    assign ifc.north_data     = nd[j+3];
    assign ifc.north_valid    = nv[j+3];
    assign ifc.drain_load     = dl[j+3];
    assign ifc.drain_shift    = ds[j+3];
    assign ifc.drain_in       = '0;
    assign ifc.drain_in_valid = 1'b0;
    assign ed[j+3]    = ifc.east_data;
    assign sd[j+3]    = ifc.south_data;
    assign ev[j+3]    = ifc.east_valid;
    assign sv[j+3]    = ifc.south_valid;
    assign ef[j+3]    = ifc.east_first;
    assign ovf_o[j+3] = ifc.ovf;
    assign err_o[j+3] = ifc.err;
    assign res16[j]   = ifc.result;
    systolic_mac_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(1'(j == 0)), .SAT(1'(j == 0))) u_pe (
      .clk (clk),
      .rst (rst),
      .pe  (ifc)
    );
  end

  typedef struct {
    logic        wv;
    logic        nv;
    logic        wf;
    logic [7:0]  wd;
    logic [7:0]  nd;
    logic [31:0] res;
    logic        ovf;
    logic        err;
    logic [7:0]  ed;
    logic [7:0]  sd;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 5; k++) begin
      wv[k] = 1'b0;
      nv[k] = 1'b0;
      wf[k] = 1'b0;
      dl[k] = 1'b0;
      ds[k] = 1'b0;
    end
  endtask

  task automatic beat(input int idx, input logic [7:0] w, input logic [7:0] n, input logic first);
    wd[idx] = w;
    nd[idx] = n;
    wv[idx] = 1'b1;
    nv[idx] = 1'b1;
    wf[idx] = first;
  endtask

  initial begin
    for (int k = 0; k < 5; k++) begin
      wd[k] = '0;
      nd[k] = '0;
    end
    idle_all();
    rst = 1'b1;

    // Basic signed stream with echo, then a misaligned beat and sticky err.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 8'd3,  8'd4,  32'd12,         1'b0, 1'b0, 8'd3,  8'd4};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'hFE, 8'd5,  32'd2,          1'b0, 1'b0, 8'hFE, 8'd5};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 8'd7,  8'hFF, 32'hFFFF_FFFB,  1'b0, 1'b0, 8'd7,  8'hFF};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 8'd9,  8'd0,  32'hFFFF_FFFB,  1'b0, 1'b1, 8'd9,  8'hFF};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 8'd2,  8'd2,  32'hFFFF_FFFF,  1'b0, 1'b1, 8'd2,  8'd2};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 8'd1,  8'd1,  32'd1,          1'b0, 1'b1, 8'd1,  8'd1};

    #12;
    chk("reset_result", res32[0], 32'd0);
    chk("reset_drain_valid", 32'(dov[0]), 32'd0);
    chk("reset_east_valid", 32'(ev[0]), 32'd0);
    chk("reset_err", 32'(err_o[0]), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      wv[0] = tbl[v].wv;
      nv[0] = tbl[v].nv;
      wf[0] = tbl[v].wf;
      wd[0] = tbl[v].wd;
      nd[0] = tbl[v].nd;
      step();
      chk($sformatf("vec%0d_result", v), res32[0], tbl[v].res);
      chk($sformatf("vec%0d_ovf", v), 32'(ovf_o[0]), 32'(tbl[v].ovf));
      chk($sformatf("vec%0d_err", v), 32'(err_o[0]), 32'(tbl[v].err));
      chk($sformatf("vec%0d_east_data", v), 32'(ed[0]), 32'(tbl[v].ed));
      chk($sformatf("vec%0d_south_data", v), 32'(sd[0]), 32'(tbl[v].sd));
      chk($sformatf("vec%0d_east_valid", v), 32'(ev[0]), 32'(tbl[v].wv));
      chk($sformatf("vec%0d_south_valid", v), 32'(sv[0]), 32'(tbl[v].nv));
      chk($sformatf("vec%0d_east_first", v), 32'(ef[0]), 32'(tbl[v].wf & tbl[v].wv));
    end

    idle_all();
    step();
    chk("idle_hold_result", res32[0], 32'd1);
    chk("idle_east_valid", 32'(ev[0]), 32'd0);
    chk("idle_east_data_hold", 32'(ed[0]), 32'd1);
    chk("idle_err_sticky", 32'(err_o[0]), 32'd1);

    // Signed 16-bit saturation and restart.
    beat(3, 8'h80, 8'h80, 1'b1);
    step();
    chk("s16_first", 32'(res16[0]), 32'd16384);
    chk("s16_first_ovf", 32'(ovf_o[3]), 32'd0);
    beat(3, 8'h80, 8'h80, 1'b0);
    step();
    chk("s16_sat", 32'(res16[0]), 32'd32767);
    chk("s16_sat_ovf", 32'(ovf_o[3]), 32'd1);
    beat(3, 8'd1, 8'd1, 1'b1);
    step();
    chk("s16_restart", 32'(res16[0]), 32'd1);
    chk("s16_restart_ovf", 32'(ovf_o[3]), 32'd0);

    // Unsigned 16-bit wrap.
    idle_all();
    beat(4, 8'd255, 8'd255, 1'b1);
    step();
    chk("u16_first", 32'(res16[1]), 32'd65025);
    beat(4, 8'd255, 8'd255, 1'b0);
    step();
    chk("u16_wrap", 32'(res16[1]), 32'd64514);
    chk("u16_wrap_ovf", 32'(ovf_o[4]), 32'd1);

    // Drain chain: accumulators 10/20/30, load, then shift out.
    idle_all();
    beat(0, 8'd2, 8'd5, 1'b1);
    beat(1, 8'd4, 8'd5, 1'b1);
    beat(2, 8'd5, 8'd6, 1'b1);
    step();
    idle_all();
    for (int k = 0; k < 3; k++) dl[k] = 1'b1;
    step();
    idle_all();
    chk("load_pe0", dout[0], 32'd10);
    chk("load_pe1", dout[1], 32'd20);
    chk("load_pe2", dout[2], 32'd30);
    chk("load_pe2_valid", 32'(dov[2]), 32'd1);
    for (int k = 0; k < 3; k++) ds[k] = 1'b1;
    step();
    chk("shift1_pe2", dout[2], 32'd20);
    chk("shift1_pe0_valid", 32'(dov[0]), 32'd0);
    step();
    chk("shift2_pe2", dout[2], 32'd10);
    chk("shift2_pe2_valid", 32'(dov[2]), 32'd1);
    step();
    chk("shift3_pe2", dout[2], 32'd0);
    chk("shift3_pe2_valid", 32'(dov[2]), 32'd0);
    chk("load_keeps_acc", res32[1], 32'd20);

    // Fire in the load cycle; load beats shift on pe1.
    idle_all();
    beat(0, 8'd1, 8'd1, 1'b0);
    dl[0] = 1'b1;
    dl[1] = 1'b1;
    ds[1] = 1'b1;
    step();
    idle_all();
    chk("fire_load_acc", res32[0], 32'd11);
    chk("fire_load_drain", dout[0], 32'd11);
    chk("fire_load_valid", 32'(dov[0]), 32'd1);
    chk("load_over_shift", dout[1], 32'd20);

    // Asynchronous reset between edges, mid-accumulation and mid-drain.
    beat(0, 8'd2, 8'd2, 1'b0);
    beat(3, 8'd1, 8'd1, 1'b0);
    step();
    chk("pre_rst_acc", res32[0], 32'd15);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_result", res32[0], 32'd0);
    chk("arst_drain", dout[0], 32'd0);
    chk("arst_drain_valid", 32'(dov[0]), 32'd0);
    chk("arst_err", 32'(err_o[0]), 32'd0);
    chk("arst_east_valid", 32'(ev[0]), 32'd0);
    chk("arst_east_data", 32'(ed[0]), 32'd0);
    chk("arst_s16_result", 32'(res16[0]), 32'd0);
    chk("arst_u16_ovf", 32'(ovf_o[4]), 32'd0);
    idle_all();
    @(negedge clk);
    rst = 1'b0;
    beat(0, 8'd2, 8'd3, 1'b1);
    step();
    chk("post_rst_first", res32[0], 32'd6);
    idle_all();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
